// File: rtl/mem_channel_arb_pkg.sv
// Shared types and constants for the DDR channel arbiter between instruction
// fetch and the load/store unit.
package mem_channel_arb_pkg;

  localparam int INDEX_W         = 19;
  localparam int DATA_W          = 64;
  localparam int LINE_W          = 512;
  localparam int FETCH_BURST_LEN = 8;
  localparam int MAX_LS_STREAK   = 4;
  localparam int STREAK_W        = $clog2(MAX_LS_STREAK + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    IF_CMD,
    IF_WAIT,
    LS_CMD,
    LS_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               write;
    logic [DATA_W-1:0]  data;
    logic [DATA_W-1:0]  mask;
    logic               burst;
  } chan_req_t;

endpackage

// File: rtl/mem_channel_arb_if.sv
// Request, response and DDR command signals of the channel arbiter.
interface mem_channel_arb_if;
  import mem_channel_arb_pkg::*;

  // A request transfers in a cycle where valid and ready are both 1. Ready is
  // raised only in a cycle the arbiter takes that request; an untransferred
  // request may be changed or withdrawn. DDR commands transfer on
  // ddr_chip_enable & ddr_ready.
  logic               if_req_valid;
  logic [INDEX_W-1:0] if_req_index;
  logic               if_req_ready;
  logic               if_cancel;
  logic               if_operation_done;
  logic [LINE_W-1:0]  if_rdata;

  logic               ls_req_valid;
  logic [INDEX_W-1:0] ls_req_index;
  logic               ls_req_write;
  logic [DATA_W-1:0]  ls_wdata;
  logic [DATA_W-1:0]  ls_wmask;
  logic               ls_req_ready;
  logic               ls_operation_done;
  logic [DATA_W-1:0]  ls_rdata;

  logic               ddr_chip_enable;
  logic [INDEX_W-1:0] ddr_index;
  logic               ddr_write_enable;
  logic               ddr_burst_mode;
  logic [DATA_W-1:0]  ddr_write_data;
  logic [DATA_W-1:0]  ddr_write_mask;
  logic               ddr_ready;
  logic               ddr_operation_done;
  logic [LINE_W-1:0]  ddr_read_data;

  modport slave (
    input  if_req_valid, if_req_index, if_cancel,
    input  ls_req_valid, ls_req_index, ls_req_write, ls_wdata, ls_wmask,
    input  ddr_ready, ddr_operation_done, ddr_read_data,
    output if_req_ready, if_operation_done, if_rdata,
    output ls_req_ready, ls_operation_done, ls_rdata,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_write_data, ddr_write_mask
  );

  modport master (
    output if_req_valid, if_req_index, if_cancel,
    output ls_req_valid, ls_req_index, ls_req_write, ls_wdata, ls_wmask,
    output ddr_ready, ddr_operation_done, ddr_read_data,
    input  if_req_ready, if_operation_done, if_rdata,
    input  ls_req_ready, ls_operation_done, ls_rdata,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_write_data, ddr_write_mask
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and load/store, with a streak counter that
// bounds how long load/store traffic can starve a waiting fetch.
module mem_arb_prio
  import mem_channel_arb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic arb_en,
  input  logic if_req_valid,
  input  logic if_cancel,
  input  logic ls_req_valid,
  output logic if_grant,
  output logic ls_grant
);

  logic [STREAK_W-1:0] streak;
  logic                fetch_eligible;
  logic                ls_wins;

  assign fetch_eligible = if_req_valid & ~if_cancel;
  assign ls_wins        = ls_req_valid & (~fetch_eligible | (streak < STREAK_MAX));
  assign ls_grant       = arb_en & ls_wins;
  assign if_grant       = arb_en & fetch_eligible & ~ls_wins;

  // Only LS grants that overtake a waiting fetch extend the streak.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (if_grant) begin
      streak <= '0;
    end else if (ls_grant) begin
      if (if_req_valid) begin
        if (streak < STREAK_MAX) streak <= streak + STREAK_W'(1);
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_channel_arb.sv
// Owns the single DDR port: takes one fetch or load/store request at a time,
// issues its command and returns the data with a one-cycle done pulse.
module mem_channel_arb
  import mem_channel_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  mem_channel_arb_if.slave  bus,
  output arb_state_t        state_dbg
);

  arb_state_t        state_q, state_d;
  chan_req_t         req_q;
  logic              cancel_q, cancel_d;
  logic              if_grant, ls_grant;
  logic              cmd_active;
  logic              if_done_q, ls_done_q;
  logic [LINE_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  mem_arb_prio u_prio (
    .clock        (clock),
    .reset_n      (reset_n),
    .arb_en       (state_q == IDLE),
    .if_req_valid (bus.if_req_valid),
    .if_cancel    (bus.if_cancel),
    .ls_req_valid (bus.ls_req_valid),
    .if_grant     (if_grant),
    .ls_grant     (ls_grant)
  );

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (if_grant)      state_d = IF_CMD;
        else if (ls_grant) state_d = LS_CMD;
      end
      IF_CMD: begin
        // A cancel that lands on the handshake cannot recall the command.
        if (bus.ddr_ready) begin
          state_d  = IF_WAIT;
          cancel_d = bus.if_cancel;
        end else if (bus.if_cancel) begin
          state_d = IDLE;
        end
      end
      IF_WAIT: begin
        if (bus.ddr_operation_done) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
        end else if (bus.if_cancel) begin
          cancel_d = 1'b1;
        end
      end
      LS_CMD:  if (bus.ddr_ready) state_d = LS_WAIT;
      LS_WAIT: if (bus.ddr_operation_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (if_grant) begin
        req_q <= '{index: bus.if_req_index, write: 1'b0, data: '0, mask: '0, burst: 1'b1};
      end else if (ls_grant) begin
        req_q <= '{index: bus.ls_req_index, write: bus.ls_req_write,
                   data: bus.ls_wdata, mask: bus.ls_wmask, burst: 1'b0};
      end
      if_done_q <= (state_q == IF_WAIT) & bus.ddr_operation_done & ~(cancel_q | bus.if_cancel);
      ls_done_q <= (state_q == LS_WAIT) & bus.ddr_operation_done;
      if ((state_q == IF_WAIT) && bus.ddr_operation_done && !(cancel_q || bus.if_cancel))
        if_rdata_q <= bus.ddr_read_data;
      if ((state_q == LS_WAIT) && bus.ddr_operation_done && !req_q.write)
        ls_rdata_q <= bus.ddr_read_data[DATA_W-1:0];
    end
  end

  assign cmd_active = (state_q == IF_CMD) || (state_q == LS_CMD);

  assign bus.if_req_ready      = if_grant;
  assign bus.ls_req_ready      = ls_grant;
  assign bus.ddr_chip_enable   = cmd_active;
  assign bus.ddr_index         = cmd_active ? req_q.index : '0;
  assign bus.ddr_write_enable  = (state_q == LS_CMD) & req_q.write;
  assign bus.ddr_burst_mode    = cmd_active & req_q.burst;
  assign bus.ddr_write_data    = (state_q == LS_CMD) ? req_q.data : '0;
  assign bus.ddr_write_mask    = (state_q == LS_CMD) ? req_q.mask : '0;
  assign bus.if_operation_done = if_done_q;
  assign bus.ls_operation_done = ls_done_q;
  assign bus.if_rdata          = if_rdata_q;
  assign bus.ls_rdata          = ls_rdata_q;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_mem_channel_arb.sv
// Bench for mem_channel_arb: arbitration table, directed corner sequences and
// randomized request rounds against a transaction-level model.
module tb_mem_channel_arb;
  import mem_channel_arb_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  arb_state_t state_dbg;

  mem_channel_arb_if bus();

  mem_channel_arb dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit                 if_pend, ls_pend;
  logic [INDEX_W-1:0] if_idx, ls_idx;
  logic               ls_wr;
  logic [DATA_W-1:0]  ls_wd, ls_wm;
  int                 ls_run;
  logic [LINE_W-1:0]  m_if_rdata;
  logic [DATA_W-1:0]  m_ls_rdata;
  bit                 exp_if_done, exp_ls_done;
  int                 win_log[$];

  typedef struct {
    bit ifv;
    bit ifc;
    bit lsv;
    bit exp_if_rdy;
    bit exp_ls_rdy;
  } arb_vec_t;
  arb_vec_t vecs[8];

  task automatic check_w(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_idle_inputs();
    bus.if_req_valid = 1'b0; bus.if_req_index = '0; bus.if_cancel = 1'b0;
    bus.ls_req_valid = 1'b0; bus.ls_req_index = '0; bus.ls_req_write = 1'b0;
    bus.ls_wdata = '0; bus.ls_wmask = '0;
    bus.ddr_ready = 1'b0; bus.ddr_operation_done = 1'b0; bus.ddr_read_data = '0;
  endtask

  task automatic model_reset();
    ls_run = 0; m_if_rdata = '0; m_ls_rdata = '0;
    exp_if_done = 1'b0; exp_ls_done = 1'b0;
    if_pend = 1'b0; ls_pend = 1'b0;
    drive_idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_ce"}, bus.ddr_chip_enable, 1'b0);
    check_w({tag, "_ddr_index"}, LINE_W'(bus.ddr_index), '0);
    check_b({tag, "_we"}, bus.ddr_write_enable, 1'b0);
    check_b({tag, "_burst"}, bus.ddr_burst_mode, 1'b0);
    check_w({tag, "_wdata"}, LINE_W'(bus.ddr_write_data), '0);
    check_w({tag, "_wmask"}, LINE_W'(bus.ddr_write_mask), '0);
    check_b({tag, "_if_done"}, bus.if_operation_done, 1'b0);
    check_b({tag, "_ls_done"}, bus.ls_operation_done, 1'b0);
    check_w({tag, "_if_rdata"}, bus.if_rdata, '0);
    check_w({tag, "_ls_rdata"}, LINE_W'(bus.ls_rdata), '0);
    check_w({tag, "_state"}, LINE_W'(state_dbg), LINE_W'(IDLE));
  endtask

  task automatic check_cmd(input bit is_ls, input logic [INDEX_W-1:0] idx, input logic wr,
                           input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] wm);
    check_b("cmd_ce", bus.ddr_chip_enable, 1'b1);
    check_w("cmd_index", LINE_W'(bus.ddr_index), LINE_W'(idx));
    check_b("cmd_burst", bus.ddr_burst_mode, !is_ls);
    check_b("cmd_we", bus.ddr_write_enable, is_ls && wr);
    if (is_ls) begin
      check_w("cmd_wdata", LINE_W'(bus.ddr_write_data), LINE_W'(wd));
      check_w("cmd_wmask", LINE_W'(bus.ddr_write_mask), LINE_W'(wm));
    end
    check_b("cmd_if_ready", bus.if_req_ready, 1'b0);
    check_b("cmd_ls_ready", bus.ls_req_ready, 1'b0);
    check_b("cmd_if_done", bus.if_operation_done, 1'b0);
    check_b("cmd_ls_done", bus.ls_operation_done, 1'b0);
  endtask

  task automatic check_quiet();
    check_b("wait_ce", bus.ddr_chip_enable, 1'b0);
    check_b("wait_if_ready", bus.if_req_ready, 1'b0);
    check_b("wait_ls_ready", bus.ls_req_ready, 1'b0);
    check_b("wait_if_done", bus.if_operation_done, 1'b0);
    check_b("wait_ls_done", bus.ls_operation_done, 1'b0);
  endtask

  // One arbitration round, entered at posedge+1 with the DUT idle. It also
  // checks the done pulse and read data left by the previous round.
  // cancel_mode: 0 none, 1 cancel during IF_WAIT, 2 cancel in IF_CMD before ddr_ready.
  task automatic run_round(input int cancel_mode, input int ready_dly, input int done_dly);
    bit                 win_ls;
    logic [INDEX_W-1:0] w_idx;
    logic               w_wr;
    logic [DATA_W-1:0]  w_wd, w_wm;
    logic [LINE_W-1:0]  rd;
    bus.if_req_valid = if_pend; bus.if_req_index = if_idx;
    bus.ls_req_valid = ls_pend; bus.ls_req_index = ls_idx; bus.ls_req_write = ls_wr;
    bus.ls_wdata = ls_wd; bus.ls_wmask = ls_wm;
    @(negedge clock);
    check_b("if_done", bus.if_operation_done, exp_if_done);
    check_b("ls_done", bus.ls_operation_done, exp_ls_done);
    check_w("if_rdata", bus.if_rdata, m_if_rdata);
    check_w("ls_rdata", LINE_W'(bus.ls_rdata), LINE_W'(m_ls_rdata));
    check_w("idle_state", LINE_W'(state_dbg), LINE_W'(IDLE));
    check_b("idle_ce", bus.ddr_chip_enable, 1'b0);
    win_ls = ls_pend && (!if_pend || ls_run < MAX_LS_STREAK);
    check_b("if_ready", bus.if_req_ready, if_pend && !win_ls);
    check_b("ls_ready", bus.ls_req_ready, win_ls);
    if (if_pend || ls_pend) win_log.push_back(bus.ls_req_ready ? 0 : 1);
    @(posedge clock); #1;
    exp_if_done = 1'b0;
    exp_ls_done = 1'b0;
    if (!if_pend && !ls_pend) return;
    if (win_ls) begin
      w_idx = ls_idx; w_wr = ls_wr; w_wd = ls_wd; w_wm = ls_wm;
      ls_run = if_pend ? ((ls_run < MAX_LS_STREAK) ? ls_run + 1 : ls_run) : 0;
      ls_pend = 1'b0; bus.ls_req_valid = 1'b0;
      cancel_mode = 0;
    end else begin
      w_idx = if_idx; w_wr = 1'b0; w_wd = '0; w_wm = '0;
      ls_run = 0;
      if_pend = 1'b0; bus.if_req_valid = 1'b0;
    end
    if (cancel_mode == 2 && ready_dly == 0) ready_dly = 1;
    if (cancel_mode == 1 && done_dly == 0) done_dly = 1;
    for (int j = 0; j < ready_dly; j++) begin
      bus.ddr_ready = 1'b0;
      if (cancel_mode == 2) bus.if_cancel = 1'b1;
      @(negedge clock);
      check_cmd(win_ls, w_idx, w_wr, w_wd, w_wm);
      @(posedge clock); #1;
      if (cancel_mode == 2) begin
        bus.if_cancel = 1'b0;
        return;
      end
    end
    bus.ddr_ready = 1'b1;
    @(negedge clock);
    check_cmd(win_ls, w_idx, w_wr, w_wd, w_wm);
    @(posedge clock); #1;
    bus.ddr_ready = 1'b0;
    for (int j = 0; j < done_dly; j++) begin
      if (cancel_mode == 1 && j == 0) bus.if_cancel = 1'b1;
      @(negedge clock);
      check_quiet();
      @(posedge clock); #1;
      bus.if_cancel = 1'b0;
    end
    rd = rand_line();
    bus.ddr_read_data = rd;
    bus.ddr_operation_done = 1'b1;
    if (win_ls) begin
      exp_ls_done = 1'b1;
      if (!w_wr) m_ls_rdata = rd[DATA_W-1:0];
    end else if (cancel_mode != 1) begin
      exp_if_done = 1'b1;
      m_if_rdata = rd;
    end
    @(posedge clock); #1;
    bus.ddr_operation_done = 1'b0;
  endtask

  task automatic flush();
    if_pend = 1'b0;
    ls_pend = 1'b0;
    run_round(0, 0, 0);
  endtask

  initial begin
    int exp_order[6];
    model_reset();
    if_idx = '0; ls_idx = '0; ls_wr = 1'b0; ls_wd = '0; ls_wm = '0;

    // Power-on reset
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    check_b("por_if_ready", bus.if_req_ready, 1'b0);
    check_b("por_ls_ready", bus.ls_req_ready, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // IDLE arbitration table, streak at 0; requests withdrawn before the edge
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 1, 0, 1};
    vecs[4] = '{1, 0, 0, 1, 0};
    vecs[5] = '{1, 0, 1, 0, 1};
    vecs[6] = '{1, 1, 0, 0, 0};
    vecs[7] = '{1, 1, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      bus.if_req_valid = vecs[i].ifv;
      bus.if_cancel    = vecs[i].ifc;
      bus.ls_req_valid = vecs[i].lsv;
      @(negedge clock);
      check_b($sformatf("arb%0d_if_ready", i), bus.if_req_ready, vecs[i].exp_if_rdy);
      check_b($sformatf("arb%0d_ls_ready", i), bus.ls_req_ready, vecs[i].exp_ls_rdy);
      #1;
      bus.if_req_valid = 1'b0; bus.if_cancel = 1'b0; bus.ls_req_valid = 1'b0;
      @(posedge clock); #1;
    end

    // Both requesters continuously valid: starvation bound
    exp_order = '{0, 0, 0, 0, 1, 0};
    if_idx = 19'h00200; ls_idx = 19'h00300; ls_wr = 1'b0;
    win_log.delete();
    for (int r = 0; r < 6; r++) begin
      if_pend = 1'b1;
      ls_pend = 1'b1;
      run_round(0, 0, 0);
    end
    for (int k = 0; k < 6; k++)
      check_w($sformatf("grant_order%0d", k), LINE_W'(win_log[k]), LINE_W'(exp_order[k]));
    flush();

    // Plain fetch, then a store
    if_idx = 19'h00040; if_pend = 1'b1;
    run_round(0, 1, 2);
    flush();
    ls_idx = 19'h00010; ls_wr = 1'b1; ls_wd = 64'hDEAD_BEEF; ls_wm = '1; ls_pend = 1'b1;
    run_round(0, 0, 1);
    flush();

    // Redirect during IF_WAIT, then a fresh fetch
    if_idx = 19'h00080; if_pend = 1'b1;
    run_round(1, 0, 2);
    if_idx = 19'h00100; if_pend = 1'b1;
    run_round(0, 1, 1);
    flush();

    // Cancel in IF_CMD before the handshake, then a waiting load is served
    if_idx = 19'h00180; if_pend = 1'b1;
    run_round(2, 2, 0);
    ls_idx = 19'h00020; ls_wr = 1'b0; ls_pend = 1'b1;
    run_round(0, 0, 0);
    flush();

    // Reset while a load waits for DDR completion
    bus.ls_req_valid = 1'b1; bus.ls_req_index = 19'h00022; bus.ls_req_write = 1'b0;
    @(negedge clock);
    check_b("rst_ls_ready", bus.ls_req_ready, 1'b1);
    @(posedge clock); #1;
    bus.ls_req_valid = 1'b0;
    bus.ddr_ready = 1'b1;
    @(posedge clock); #1;
    bus.ddr_ready = 1'b0;
    @(negedge clock);
    check_w("rst_pre_state", LINE_W'(state_dbg), LINE_W'(LS_WAIT));
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    bus.ddr_operation_done = 1'b1;
    bus.ddr_read_data = rand_line();
    @(posedge clock); #1;
    bus.ddr_operation_done = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst_after_done");
    reset_n = 1'b1;
    model_reset();
    @(posedge clock); #1;
    ls_idx = 19'h00033; ls_wr = 1'b0; ls_wd = '0; ls_wm = '0; ls_pend = 1'b1;
    run_round(0, 1, 1);
    flush();

    // Randomized rounds
    for (int r = 0; r < 80; r++) begin
      int cm;
      if (!if_pend && $urandom_range(0, 99) < 60) begin
        if_pend = 1'b1;
        if_idx = INDEX_W'($urandom);
      end
      if (!ls_pend && $urandom_range(0, 99) < 60) begin
        ls_pend = 1'b1;
        ls_idx = INDEX_W'($urandom);
        ls_wr = $urandom_range(0, 1) == 1;
        ls_wd = {$urandom, $urandom};
        ls_wm = {$urandom, $urandom};
      end
      if (!if_pend && !ls_pend) begin
        ls_pend = 1'b1;
        ls_idx = INDEX_W'($urandom);
        ls_wr = 1'b0;
      end
      cm = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 2) : 0;
      run_round(cm, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
